// File: rtl/ac97_cmd_arbiter.sv
// rtl/ac97_cmd_arbiter.sv - round-robin arbiter for the shared AC97 command slot
//
// Purpose: grants one of NUM_REQ requesters at a time, presents its latched
// address/data on the command slot for HOLD_FRAMES rising edges of the frame
// strobe, then acknowledges that requester with a one-cycle req_ack pulse.
//
// Optional feature: define AC97_CMD_TIMEOUT_EN to abort a command after
// TIMEOUT_CYCLES clocks without a ready edge (req_ack + req_err pulse together).
//
// Ports:
//   clock           system clock
//   reset_b         synchronous active-low reset
//   ready           frame strobe from the assembler (bit-clock domain)
//   req_valid       per-requester request
//   req_addr        packed 8-bit register addresses, requester i at [8i+7:8i]
//   req_data        packed 16-bit write data, requester i at [16i+15:16i]
//   req_ack         one-cycle completion pulse per requester
//   req_err         one-cycle abort flag alongside req_ack
//   command_address address to the assembler (8'h80 when idle)
//   command_data    data to the assembler
//   command_valid   command slot valid
//   busy            high while not idle
//   grant_idx       current or last granted requester

module ac97_cmd_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int HOLD_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                    clock,
    input  logic                    reset_b,
    input  logic                    ready,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_addr,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    req_err,
    output logic [7:0]              command_address,
    output logic [15:0]             command_data,
    output logic                    command_valid,
    output logic                    busy,
    output logic [2:0]              grant_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_rdy_s1;
    logic        r_rdy_s2;
    logic        r_rdy_s3;
    logic [1:0]  r_fill;
    logic        w_ready_rise;

    logic [2:0]  r_ptr;
    logic [2:0]  r_grant;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic [3:0]  r_frame_cnt;

    logic        w_found;
    logic [2:0]  w_sel;
    logic [7:0]  w_sel_addr;
    logic [15:0] w_sel_data;
    logic        w_hold_done;
    logic        w_timeout_hit;
    int          v_best;
    int          v_dist;

    // The synchroniser flops come out of reset at 0, so the first real samples
    // need three clocks to reach the edge flop. r_fill suppresses edge
    // detection until then, so a ready already high at reset release is never
    // mistaken for a new frame.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_rdy_s1 <= 1'b0;
            r_rdy_s2 <= 1'b0;
            r_rdy_s3 <= 1'b0;
            r_fill   <= 2'd0;
        end else begin
            r_rdy_s1 <= ready;
            r_rdy_s2 <= r_rdy_s1;
            r_rdy_s3 <= r_rdy_s2;
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign w_ready_rise = r_rdy_s2 & ~r_rdy_s3 & (r_fill == 2'd3);

    // Round robin: choose the asserted requester closest to r_ptr, measured
    // as a forward distance modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        v_best  = NUM_REQ;
        v_dist  = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            v_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
            if (req_valid[j] && (v_dist < v_best)) begin
                v_best  = v_dist;
                w_sel   = 3'(j);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_addr = 8'h00;
        w_sel_data = 16'h0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == 3'(k)) begin
                w_sel_addr = req_addr[8*k +: 8];
                w_sel_data = req_data[16*k +: 16];
            end
        end
    end

    assign w_hold_done = w_ready_rise && (r_frame_cnt == 4'(HOLD_FRAMES - 1));

`ifdef AC97_CMD_TIMEOUT_EN
    logic [19:0] r_to_cnt;
    logic        r_timed_out;

    // Counts ISSUE cycles since the last frame edge; any edge restarts it.
    assign w_timeout_hit = !w_ready_rise && (r_to_cnt == 20'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_to_cnt    <= 20'd0;
            r_timed_out <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt    <= w_ready_rise ? 20'd0 : r_to_cnt + 20'd1;
            r_timed_out <= w_timeout_hit;
        end else begin
            r_to_cnt <= 20'd0;
        end
    end

    assign req_err = (r_state == S_DONE) && r_timed_out;
`else
    assign w_timeout_hit = 1'b0;
    assign req_err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: if (w_hold_done || w_timeout_hit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping and frame counting
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_ptr       <= 3'd0;
            r_grant     <= 3'd0;
            r_addr      <= 8'h80;
            r_data      <= 16'h0000;
            r_frame_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_addr  <= w_sel_addr;
                        r_data  <= w_sel_data;
                        r_ptr   <= (w_sel == 3'(NUM_REQ - 1)) ? 3'd0 : w_sel + 3'd1;
                    end
                end
                S_ISSUE: begin
                    if (w_ready_rise) begin
                        r_frame_cnt <= r_frame_cnt + 4'd1;
                    end
                end
                default: r_frame_cnt <= 4'd0;
            endcase
        end
    end

    // Output logic
    always_comb begin
        command_valid   = 1'b0;
        command_address = 8'h80;
        command_data    = 16'h0000;
        busy            = (r_state != S_IDLE);
        grant_idx       = r_grant;
        if (r_state == S_ISSUE) begin
            command_valid   = 1'b1;
            command_address = r_addr;
            command_data    = r_data;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ack[k] = (r_state == S_DONE) && (r_grant == 3'(k));
        end
    end

endmodule
